// File: rtl/rx_dcm_lock_ctrl.sv
// rx_dcm_lock_ctrl
// Supervises the receive DCM. It pulses the DCM reset, qualifies LOCKED
// through a 2-flop synchronizer, and releases the RX engine reset only after
// a sustained lock. It detects loss of lock and retries on lock timeout.
// All logic runs on the free-running rxclk_in. This keeps supervision alive
// while the DCM output clocks are absent.
//
// Ports
//   rxclk_in     : free-running reference clock (only clock domain)
//   reset        : async active-low block reset
//   locked       : DCM LOCKED, asynchronous to rxclk_in
//   force_relock : 1-cycle request to restart the DCM
//   clear_stats  : 1-cycle synchronous clear of both statistics counters
//   dcm_rst      : active-high DCM reset
//   engine_rst   : active-high RX engine reset (registered)
//   rx_ready     : lock qualified, always !engine_rst
//   retry_cnt    : lock timeouts, saturating
//   loss_cnt     : losses of lock while running, saturating
module rx_dcm_lock_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int DCM_RST_CYCLES     = 8,
  parameter int CNT_W              = 8
) (
  input  logic             rxclk_in,
  input  logic             reset,
  input  logic             locked,
  input  logic             force_relock,
  input  logic             clear_stats,
  output logic             dcm_rst,
  output logic             engine_rst,
  output logic             rx_ready,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  // One shared timer serves every state. It must hold values 0..max-1.
  localparam int MAX_A = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
  localparam int MAX_T = (MAX_A > DCM_RST_CYCLES) ? MAX_A : DCM_RST_CYCLES;
  localparam int TW    = $clog2(MAX_T);

  localparam logic [TW-1:0] RST_LAST    = TW'(DCM_RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);

  localparam logic [1:0] S_DCM_RST   = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             sync1_q, locked_s_q;
  logic             engine_rst_q, engine_rst_d;
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             retry_ev, loss_ev;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TW'(1);
    retry_ev = 1'b0;
    loss_ev  = 1'b0;
    case (state_q)
      S_DCM_RST: begin
        // force_relock restarts the pulse, so dcm_rst is stretched.
        if (force_relock)          tmr_d = '0;
        else if (tmr_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (force_relock) begin
          state_d = S_DCM_RST;
          tmr_d   = '0;
        end else if (locked_s_q) begin
          state_d = S_STABLE;
          tmr_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          state_d  = S_DCM_RST;
          tmr_d    = '0;
          retry_ev = 1'b1;
        end
      end
      S_STABLE: begin
        // A dropout sends us back to WAIT_LOCK with a fresh timeout. This is
        // not counted as a retry.
        if (force_relock || !locked_s_q) begin
          state_d = force_relock ? S_DCM_RST : S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == STABLE_LAST) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end
      end
      default: begin  // S_RUN
        tmr_d = '0;
        if (force_relock) begin
          state_d = S_DCM_RST;
        end else if (!locked_s_q) begin
          state_d = S_DCM_RST;
          loss_ev = 1'b1;
        end
      end
    endcase
  end

  // engine_rst is computed from the next state. It therefore changes on the
  // same edge that enters or leaves RUN.
  always_comb begin
    engine_rst_d = (state_d != S_RUN);
    retry_cnt_d  = retry_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    if (clear_stats) begin
      retry_cnt_d = '0;
      loss_cnt_d  = '0;
    end else begin
      if (retry_ev && !(&retry_cnt_q)) retry_cnt_d = retry_cnt_q + CNT_W'(1);
      if (loss_ev  && !(&loss_cnt_q))  loss_cnt_d  = loss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rxclk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= S_DCM_RST;
      tmr_q        <= '0;
      sync1_q      <= 1'b0;
      locked_s_q   <= 1'b0;
      engine_rst_q <= 1'b1;
      retry_cnt_q  <= '0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      sync1_q      <= locked;
      locked_s_q   <= sync1_q;
      engine_rst_q <= engine_rst_d;
      retry_cnt_q  <= retry_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  // dcm_rst is decoded straight from the state flop. An async reset therefore
  // re-asserts it at once.
  assign dcm_rst    = (state_q == S_DCM_RST);
  assign engine_rst = engine_rst_q;
  assign rx_ready   = !engine_rst_q;
  assign retry_cnt  = retry_cnt_q;
  assign loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_rx_dcm_lock_ctrl.sv
module tb_rx_dcm_lock_ctrl;
  localparam int LSC = 16, TO = 100, DRC = 4, W = 8;

  logic rxclk_in = 1'b0;
  logic reset = 1'b0, locked = 1'b0, force_relock = 1'b0, clear_stats = 1'b0;
  logic dcm_rst, engine_rst, rx_ready;
  logic [W-1:0] retry_cnt, loss_cnt;

  int n_chk = 0, n_fail = 0;

  // Reference model. Phase: 0 reset pulse, 1 waiting, 2 qualifying, 3 running.
  // m_age counts the cycles spent in the current phase.
  int   m_ph = 0, m_age = 0, m_retry = 0, m_loss = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0;

  rx_dcm_lock_ctrl #(.LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT(TO),
                     .DCM_RST_CYCLES(DRC), .CNT_W(W)) dut (
    .rxclk_in(rxclk_in), .reset(reset), .locked(locked),
    .force_relock(force_relock), .clear_stats(clear_stats),
    .dcm_rst(dcm_rst), .engine_rst(engine_rst), .rx_ready(rx_ready),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt));

  always #5 rxclk_in = ~rxclk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge rxclk_in or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_age = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0; m_loss = 0;
    end else begin
      int  nph;
      bit  restart, ev_r, ev_l;
      nph = m_ph; restart = 0; ev_r = 0; ev_l = 0;
      if (force_relock) begin
        nph = 0; restart = 1;
      end else begin
        case (m_ph)
          0: if (m_age == DRC - 1) nph = 1;
          1: if (m_s2) nph = 2; else if (m_age == TO - 1) begin nph = 0; ev_r = 1; end
          2: if (!m_s2) nph = 1; else if (m_age == LSC - 1) nph = 3;
          default: if (!m_s2) begin nph = 0; ev_l = 1; end
        endcase
      end
      m_age = (restart || nph != m_ph) ? 0 : m_age + 1;
      m_ph  = nph;
      if (clear_stats) begin
        m_retry = 0; m_loss = 0;
      end else begin
        if (ev_r) m_retry = (m_retry == 255) ? 255 : m_retry + 1;
        if (ev_l) m_loss  = (m_loss  == 255) ? 255 : m_loss + 1;
      end
      m_s2 = m_s1;
      m_s1 = locked;
    end
  end

  // Compare the DUT against the model on every cycle out of reset.
  always @(negedge rxclk_in) begin
    if (reset) begin
      chk("dcm_rst",    32'(dcm_rst),    32'(m_ph == 0));
      chk("engine_rst", 32'(engine_rst), 32'(m_ph != 3));
      chk("rx_ready",   32'(rx_ready),   32'(m_ph == 3));
      chk("retry_cnt",  32'(retry_cnt),  32'(m_retry));
      chk("loss_cnt",   32'(loss_cnt),   32'(m_loss));
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(negedge rxclk_in);
    chk("rst_dcm_rst", 32'(dcm_rst), 1);
    chk("rst_engine_rst", 32'(engine_rst), 1);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_loss", 32'(loss_cnt), 0);

    // Power-up
    reset = 1'b1;
    cnt = 0;
    while (dcm_rst && cnt < 20) begin cnt++; @(negedge rxclk_in); end
    chk("pwrup_dcm_width", 32'(cnt), 4);
    repeat (10) @(negedge rxclk_in);
    locked = 1'b1;
    cnt = 0;
    while (!rx_ready && cnt < 100) begin @(negedge rxclk_in); cnt++; end
    chk("pwrup_release_lat", 32'(cnt), 19);  // 2 sync + 1 entry + 16 stable
    chk("pwrup_retry", 32'(retry_cnt), 0);

    // Loss in RUN
    repeat (5) @(negedge rxclk_in);
    locked = 1'b0;
    cnt = 0;
    while (!engine_rst && cnt < 10) begin @(negedge rxclk_in); cnt++; end
    chk("loss_latency", 32'(cnt), 3);
    cnt = 0;
    while (dcm_rst && cnt < 20) begin cnt++; @(negedge rxclk_in); end
    chk("loss_dcm_width", 32'(cnt), 4);
    chk("loss_cnt_one", 32'(loss_cnt), 1);
    locked = 1'b1;
    cnt = 0;
    while (!rx_ready && cnt < 200) begin @(negedge rxclk_in); cnt++; end
    chk("relock_ready", 32'(rx_ready), 1);

    // force_relock in RUN, then again in the second DCM_RST cycle
    repeat (3) @(negedge rxclk_in);
    force_relock = 1'b1;
    @(negedge rxclk_in);
    force_relock = 1'b0;
    cnt = 0;
    while (dcm_rst && cnt < 30) begin
      cnt++;
      force_relock = (cnt == 2);
      @(negedge rxclk_in);
    end
    force_relock = 1'b0;
    chk("force_dcm_width", 32'(cnt), 6);
    chk("force_retry", 32'(retry_cnt), 0);
    chk("force_loss", 32'(loss_cnt), 1);

    // clear_stats in the same cycle as a lock timeout
    locked = 1'b0;
    cnt = 0;
    while (!(m_ph == 1 && m_age == TO - 1) && cnt < 500) begin @(negedge rxclk_in); cnt++; end
    chk("clr_wait_bound", 32'(cnt < 500), 1);
    clear_stats = 1'b1;
    @(negedge rxclk_in);
    clear_stats = 1'b0;
    chk("clr_timeout_dcm", 32'(dcm_rst), 1);
    chk("clr_retry", 32'(retry_cnt), 0);
    chk("clr_loss", 32'(loss_cnt), 0);

    // Lock timeout: a 104-cycle period and a counting retry_cnt
    for (int k = 1; k <= 3; k++) begin
      cnt = 0;
      while (dcm_rst && cnt < 300) begin @(negedge rxclk_in); cnt++; end
      while (!dcm_rst && cnt < 300) begin @(negedge rxclk_in); cnt++; end
      chk("tmo_period", 32'(cnt), 104);
      chk("tmo_retry", 32'(retry_cnt), 32'(k));
    end
    repeat (297 * 104 + 3) @(negedge rxclk_in);
    chk("tmo_saturate", 32'(retry_cnt), 255);

    // Unstable lock: qualification restarts after a captured dropout
    cnt = 0;
    while (dcm_rst && cnt < 20) begin @(negedge rxclk_in); cnt++; end
    locked = 1'b1;
    repeat (10) @(negedge rxclk_in);
    locked = 1'b0;
    @(negedge rxclk_in);
    locked = 1'b1;
    cnt = 0;
    while (!rx_ready && cnt < 100) begin @(negedge rxclk_in); cnt++; end
    chk("unstable_release_lat", 32'(cnt), 19);
    chk("unstable_loss", 32'(loss_cnt), 0);

    // Async reset while qualifying
    force_relock = 1'b1;
    @(negedge rxclk_in);
    force_relock = 1'b0;
    cnt = 0;
    while (m_ph != 2 && cnt < 50) begin @(negedge rxclk_in); cnt++; end
    repeat (3) @(negedge rxclk_in);
    chk("ar_in_stable", 32'(m_ph), 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_dcm_rst", 32'(dcm_rst), 1);
    chk("ar_engine_rst", 32'(engine_rst), 1);
    chk("ar_rx_ready", 32'(rx_ready), 0);
    chk("ar_retry", 32'(retry_cnt), 0);
    chk("ar_loss", 32'(loss_cnt), 0);
    repeat (2) @(negedge rxclk_in);
    reset = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge rxclk_in);
      if ($urandom_range(0, (i < 3000) ? 39 : 149) == 0) locked = ~locked;
      force_relock = ($urandom_range(0, 199) == 0);
      clear_stats  = ($urandom_range(0, 299) == 0);
    end
    force_relock = 1'b0;
    clear_stats  = 1'b0;
    repeat (2) @(negedge rxclk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
